challenge_sampler: RTL and testbench
====================================

CHALLENGE_SAMPLER -- requirements
Module: challenge_sampler

Interface
REQ-001 SHALL have parameter CHAL_W, default 64, giving the challenge width in bits (legal range 8..256).
REQ-002 SHALL have parameter WARMUP, default 16, giving the number of generator bits discarded before collection (legal range 0..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk (1 bit, rising edge) and reset_n (1 bit, active-low, asynchronous).
REQ-004 SHALL have the following ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- start  in  1  request a new challenge
- asg_bit  in  1  pseudo-random bit from the upstream generator
- asg_enable  out  1  step enable to the generator
- busy  out  1  high in any state except IDLE
- chal_valid  out  1  challenge available
- chal_ready  in  1  consumer accepts the challenge
- challenge  out  CHAL_W  collected challenge
- health_fail  out  1  one-cycle pulse when a stuck pattern is rejected

Function
REQ-005 SHALL implement the states IDLE, WARMUP, COLLECT and HOLD.
REQ-006 IDLE: when start=1 at a clock edge, SHALL clear the challenge register to 0 and go to WARMUP; if WARMUP=0, SHALL go to COLLECT instead.
REQ-007 WARMUP: asg_enable=1; asg_bit ignored; SHALL go to COLLECT after exactly WARMUP edges.
REQ-008 COLLECT: asg_enable=1; each edge SHALL shift challenge <= {challenge[CHAL_W-2:0], asg_bit}, so the first collected bit ends in the MSB.
REQ-009 After exactly CHAL_W collect edges, SHALL go to HOLD.
REQ-010 Latency: chal_valid SHALL rise WARMUP+CHAL_W edges after the edge that samples start.
REQ-011 HOLD: asg_enable=0; chal_valid=1; challenge SHALL hold stable until the chal_valid&&chal_ready edge.
REQ-012 On that handshake edge, SHALL go to IDLE; if start=1 on the same edge, SHALL go directly to WARMUP (or COLLECT when WARMUP=0) and clear the challenge register.
REQ-013 start SHALL be ignored in WARMUP and COLLECT, and in HOLD without a handshake.
REQ-014 chal_ready SHALL be ignored outside HOLD.
REQ-015 challenge SHALL show the shift register at all times and is defined only while chal_valid=1.
REQ-016 The bit counter SHALL be $clog2(CHAL_W) bits wide (warmup counter 8 bits), SHALL reset to 0 on each state entry, and SHALL never wrap inside a state.

Reset
REQ-017 reset_n low SHALL immediately force state=IDLE, counters=0, challenge=0, asg_enable=0, busy=0, chal_valid=0 and health_fail=0, including during COLLECT or HOLD.
REQ-018 A partially collected challenge SHALL be discarded by reset and never presented.
REQ-019 After reset release, the block SHALL wait for a new start.

Configuration
REQ-020 With macro CHAL_HEALTH_EN defined, at the end of COLLECT, an all-zero or all-ones challenge SHALL pulse health_fail for one cycle, SHALL not enter HOLD, and SHALL restart at WARMUP with the register cleared.
REQ-021 Without CHAL_HEALTH_EN, health_fail SHALL be tied 0 and every collected pattern SHALL go to HOLD.

Structure
REQ-022 Package challenge_pkg SHALL hold the state enum type chal_state_t and the constants CHAL_W_DEFAULT=64 and WARMUP_DEFAULT=16.
REQ-023 The FSM, counters and shift register SHALL live in challenge_sampler, with no sub-module; the generator is instantiated by the parent.

Verification (CHAL_W=8, WARMUP=2 unless stated)
REQ-024 A start pulse, 2 discarded bits, then asg_bit=1,0,1,1,0,0,1,0 SHALL give chal_valid on the 10th edge after start with challenge=8'hB2.
REQ-025 Holding chal_ready=0 for 5 cycles in HOLD SHALL keep challenge=8'hB2 and chal_valid=1 with asg_enable=0; chal_ready=1 SHALL return to IDLE on the next edge.
REQ-026 start and chal_ready both high on the handshake edge SHALL give busy=1, challenge=0 and WARMUP entry, with the next challenge valid 10 edges later.
REQ-027 reset_n low for 1 cycle in the 4th COLLECT cycle SHALL give all outputs 0 asynchronously and no chal_valid until a new start.
REQ-028 With CHAL_HEALTH_EN and asg_bit=0 constant, SHALL give a health_fail pulse every 10 cycles and chal_valid never high; without the macro, SHALL give challenge=8'h00 with chal_valid=1.
REQ-029 With WARMUP=0, a start pulse SHALL give chal_valid exactly 8 edges later.

Source files
------------

// File: rtl/challenge_pkg.sv
// Shared types and default sizing for the challenge sampler.
package challenge_pkg;

  localparam int CHAL_W_DEFAULT = 64;
  localparam int WARMUP_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COLLECT = 2'd2,
    ST_HOLD    = 2'd3
  } chal_state_t;

endpackage

// File: rtl/challenge_sampler.sv
// Collects CHAL_W generator bits (after WARMUP discarded bits) into a challenge held until accepted.
// Optional stuck-pattern rejection under macro CHAL_HEALTH_EN.
module challenge_sampler
  import challenge_pkg::*;
#(
  parameter int CHAL_W = CHAL_W_DEFAULT,
  parameter int WARMUP = WARMUP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              asg_bit,
  output logic              asg_enable,
  output logic              busy,
  output logic              chal_valid,
  input  logic              chal_ready,
  output logic [CHAL_W-1:0] challenge,
  output logic              health_fail
);

  localparam int BW = $clog2(CHAL_W);
  // With WARMUP=0 the warmup state is never entered, so the wrapped value is harmless.
  localparam logic [7:0]    WARM_LAST = 8'(WARMUP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CHAL_W - 1);
  localparam chal_state_t   RUN_ENTRY = (WARMUP == 0) ? ST_COLLECT : ST_WARMUP;

  chal_state_t       state_q;
  logic [7:0]        wcnt_q;
  logic [BW-1:0]     bcnt_q;
  logic [CHAL_W-1:0] shreg_q;
  logic              asg_enable_q;
  logic              busy_q;
  logic              chal_valid_q;
  logic              health_fail_q;

  logic [CHAL_W-1:0] shreg_d;
  logic              stuck;

  assign shreg_d = {shreg_q[CHAL_W-2:0], asg_bit};

`ifdef CHAL_HEALTH_EN
  assign stuck = (shreg_d == '0) || (&shreg_d);
`else
  assign stuck = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wcnt_q        <= '0;
      bcnt_q        <= '0;
      shreg_q       <= '0;
      asg_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      chal_valid_q  <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      health_fail_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= RUN_ENTRY;
            wcnt_q       <= '0;
            bcnt_q       <= '0;
            shreg_q      <= '0;
            asg_enable_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_WARMUP: begin
          if (wcnt_q == WARM_LAST) begin
            state_q <= ST_COLLECT;
            wcnt_q  <= '0;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        ST_COLLECT: begin
          shreg_q <= shreg_d;
          if (bcnt_q == BIT_LAST) begin
            bcnt_q <= '0;
            if (stuck) begin
              health_fail_q <= 1'b1;
              state_q       <= RUN_ENTRY;
              shreg_q       <= '0;
            end else begin
              state_q      <= ST_HOLD;
              asg_enable_q <= 1'b0;
              chal_valid_q <= 1'b1;
            end
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (chal_ready) begin
            chal_valid_q <= 1'b0;
            if (start) begin
              state_q      <= RUN_ENTRY;
              wcnt_q       <= '0;
              bcnt_q       <= '0;
              shreg_q      <= '0;
              asg_enable_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign asg_enable  = asg_enable_q;
  assign busy        = busy_q;
  assign chal_valid  = chal_valid_q;
  assign challenge   = shreg_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_challenge_sampler.sv
// Bench: two samplers (CHAL_W=8, WARMUP=2 and WARMUP=0) driven in lockstep, checked against a bit-queue model.
module tb_challenge_sampler;

`ifdef CHAL_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic asg_bit = 1'b0;
  logic chal_ready = 1'b0;

  logic [1:0] en_o, busy_o, valid_o, hf_o;
  logic [7:0] chal [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  challenge_sampler #(.CHAL_W(8), .WARMUP(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .asg_bit(asg_bit),
    .asg_enable(en_o[0]), .busy(busy_o[0]), .chal_valid(valid_o[0]),
    .chal_ready(chal_ready), .challenge(chal[0]), .health_fail(hf_o[0]));

  challenge_sampler #(.CHAL_W(8), .WARMUP(0)) dut0w (
    .clk(clk), .reset_n(reset_n), .start(start), .asg_bit(asg_bit),
    .asg_enable(en_o[1]), .busy(busy_o[1]), .chal_valid(valid_o[1]),
    .chal_ready(chal_ready), .challenge(chal[1]), .health_fail(hf_o[1]));

  // Model: edges since start, list of collected bits, and a hold flag.
  bit   m_run [2];
  bit   m_hold [2];
  bit   m_hf [2];
  int   m_n [2];
  int   m_nb [2];
  logic m_bits [2][0:7];

  function automatic int warm(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit uniform(int i, logic b);
    bit u = 1'b1;
    for (int j = 0; j < 7; j++) if (m_bits[i][j] != b) u = 1'b0;
    return u;
  endfunction

  function automatic logic [7:0] exp_chal(int i);
    logic [7:0] v = 8'h00;
    for (int j = 0; j < m_nb[i]; j++) v = {v[6:0], m_bits[i][j]};
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] <= 1'b0; m_hold[i] <= 1'b0; m_hf[i] <= 1'b0; m_n[i] <= 0; m_nb[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_hf[i] <= 1'b0;
        if (m_hold[i]) begin
          if (chal_ready) begin
            m_hold[i] <= 1'b0;
            if (start) begin m_run[i] <= 1'b1; m_n[i] <= 0; m_nb[i] <= 0; end
          end
        end else if (m_run[i]) begin
          if (m_n[i] >= warm(i)) begin
            m_bits[i][m_nb[i]] <= asg_bit;
            m_nb[i] <= m_nb[i] + 1;
          end
          m_n[i] <= m_n[i] + 1;
          if (m_n[i] + 1 == warm(i) + 8) begin
            if (HEALTH && uniform(i, asg_bit)) begin
              m_hf[i] <= 1'b1; m_n[i] <= 0; m_nb[i] <= 0;
            end else begin
              m_run[i] <= 1'b0; m_hold[i] <= 1'b1;
            end
          end
        end else if (start) begin
          m_run[i] <= 1'b1; m_n[i] <= 0; m_nb[i] <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_run[i] | m_hold[i]));
        chk($sformatf("asg_enable[%0d]", i), 32'(en_o[i]), 32'(m_run[i]));
        chk($sformatf("chal_valid[%0d]", i), 32'(valid_o[i]), 32'(m_hold[i]));
        chk($sformatf("health_fail[%0d]", i), 32'(hf_o[i]), 32'(m_hf[i]));
        chk($sformatf("challenge[%0d]", i), 32'(chal[i]), 32'(exp_chal(i)));
      end
    end
  end

  // Bits for edges 1..10 of the first run: two discarded, then 1,0,1,1,0,0,1,0.
  logic seq_bits [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic tick();
    @(negedge clk);
  endtask

  // mode 0: seq_bits, 1: random, 2: constant zero. Returns edge count to dut valid, or -1.
  task automatic run_to_valid(input int mode, output int n_dut, output int n_w0, output int n_hf);
    n_dut = -1; n_w0 = -1; n_hf = 0;
    for (int k = 1; k <= 30; k++) begin
      case (mode)
        0: asg_bit = (k <= 10) ? seq_bits[k-1] : 1'b0;
        1: asg_bit = 1'($urandom_range(0, 1));
        default: asg_bit = 1'b0;
      endcase
      tick();
      if (hf_o[0]) n_hf++;
      if (valid_o[1] && n_w0 < 0) n_w0 = k;
      if (valid_o[0]) begin n_dut = k; break; end
    end
  endtask

  int n_dut, n_w0, n_hf, vcnt;

  initial begin
    repeat (2) tick();
    chk("reset busy", 32'(busy_o), 32'h0);
    chk("reset valid", 32'(valid_o), 32'h0);
    chk("reset challenge", 32'(chal[0]), 32'h0);
    cmp_en = 1'b1;
    reset_n = 1'b1;
    tick();

    // First challenge, expected 8'hB2 after 10 edges; WARMUP=0 copy sees 8'hEC at 8.
    start = 1'b1; tick(); start = 1'b0;
    run_to_valid(0, n_dut, n_w0, n_hf);
    chk("latency warmup2", 32'(n_dut), 32'd10);
    chk("challenge B2", 32'(chal[0]), 32'hB2);
    chk("latency warmup0", 32'(n_w0), 32'd8);
    chk("challenge w0 EC", 32'(chal[1]), 32'hEC);

    asg_bit = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold valid", 32'(valid_o[0]), 32'h1);
      chk("hold challenge", 32'(chal[0]), 32'hB2);
      chk("hold asg_enable", 32'(en_o[0]), 32'h0);
    end
    chal_ready = 1'b1; tick(); chal_ready = 1'b0;
    chk("idle after accept", 32'(busy_o), 32'h0);

    // Back-to-back: start together with the handshake.
    start = 1'b1; tick(); start = 1'b0;
    run_to_valid(1, n_dut, n_w0, n_hf);
    chk("second latency", 32'(n_dut), 32'd10);
    start = 1'b1; chal_ready = 1'b1; tick(); start = 1'b0; chal_ready = 1'b0;
    chk("restart busy", 32'(busy_o[0]), 32'h1);
    chk("restart challenge", 32'(chal[0]), 32'h0);
    chk("restart asg_enable", 32'(en_o[0]), 32'h1);
    chk("restart valid", 32'(valid_o[0]), 32'h0);
    run_to_valid(1, n_dut, n_w0, n_hf);
    chk("restart latency", 32'(n_dut), 32'd10);
    chal_ready = 1'b1; tick(); chal_ready = 1'b0;

    // Reset during the 4th collect cycle.
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) begin asg_bit = 1'b1; tick(); end
    #2 reset_n = 1'b0;
    #1;
    chk("async reset busy", 32'(busy_o[0]), 32'h0);
    chk("async reset enable", 32'(en_o[0]), 32'h0);
    chk("async reset challenge", 32'(chal[0]), 32'h0);
    tick(); reset_n = 1'b1;
    vcnt = 0;
    repeat (20) begin tick(); if (valid_o[0] || busy_o[0]) vcnt++; end
    chk("no activity after reset", 32'(vcnt), 32'd0);

    // Constant-zero generator.
    start = 1'b1; tick(); start = 1'b0;
    run_to_valid(2, n_dut, n_w0, n_hf);
    if (HEALTH) begin
      chk("stuck never valid", 32'(n_dut), 32'hFFFF_FFFF);
      chk("stuck pulse count", 32'(n_hf), 32'd3);
    end else begin
      chk("zero latency", 32'(n_dut), 32'd10);
      chk("zero challenge", 32'(chal[0]), 32'h00);
    end

    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
